// File: rtl/coin_accumulator_if.sv
// Coin accumulator bus: transaction controls in, comparison result and inventory out.
// The cancel wire exists only when COIN_CANCEL_EN is defined.
interface coin_accumulator_if;
    logic       start;
    logic [3:0] cost;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       enter;
    logic       ack;
`ifdef COIN_CANCEL_EN
    logic       cancel;
`endif
    logic       less;
    logic       exact;
    logic       more;
    logic [3:0] change;
    logic [1:0] Pentagons;
    logic [1:0] Triangles;
    logic [1:0] Circles;
    logic [3:0] paid;
    logic       result_valid;
    logic       busy;
    logic       coin_reject;

    modport master (
`ifdef COIN_CANCEL_EN
        output cancel,
`endif
        output start, cost, coin_valid, coin_type, enter, ack,
        input  less, exact, more, change, Pentagons, Triangles, Circles,
        input  paid, result_valid, busy, coin_reject
    );

    modport slave (
`ifdef COIN_CANCEL_EN
        input  cancel,
`endif
        input  start, cost, coin_valid, coin_type, enter, ack,
        output less, exact, more, change, Pentagons, Triangles, Circles,
        output paid, result_valid, busy, coin_reject
    );
endinterface

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects coins against a latched cost, compares on enter, keeps inventory.
// Latency: all outputs registered; result_valid rises one cycle after enter.
// Backpressure: result held until ack; refused coins pulse coin_reject. Optional cancel: COIN_CANCEL_EN.
module coin_accumulator (
    input  logic                clock,
    input  logic                reset_L,
    coin_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_t;

    state_t     state, state_nxt;
    logic [3:0] cost_q, cost_nxt;
    logic [3:0] paid_q, paid_nxt;
    logic [1:0] sess_p, sess_p_nxt, sess_t, sess_t_nxt, sess_c, sess_c_nxt;
    logic [1:0] inv_p, inv_p_nxt, inv_t, inv_t_nxt, inv_c, inv_c_nxt;
    logic       less_q, less_nxt, exact_q, exact_nxt, more_q, more_nxt;
    logic [3:0] change_q, change_nxt;
    logic       rv_q, rv_nxt, busy_q, busy_nxt, reject_q, reject_nxt;

    logic [2:0] coin_val;
    logic [1:0] coin_cnt;
    logic [4:0] coin_sum;
    logic       coin_ok;
    logic [4:0] diff;

    function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd3) ? 2'd3 : s[1:0];
    endfunction

    // Coin decode and acceptance test against the current running total.
    always_comb begin
        coin_val = 3'd0;
        coin_cnt = 2'd0;
        case (bus.coin_type)
            2'b01:   begin coin_val = 3'd1; coin_cnt = sess_c; end
            2'b10:   begin coin_val = 3'd3; coin_cnt = sess_t; end
            2'b11:   begin coin_val = 3'd5; coin_cnt = sess_p; end
            default: begin coin_val = 3'd0; coin_cnt = 2'd0;   end
        endcase
        coin_sum = {1'b0, paid_q} + {2'b00, coin_val};
        coin_ok  = bus.coin_valid && (bus.coin_type != 2'b00) && !coin_sum[4] && (coin_cnt != 2'd3);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cost_nxt   = cost_q;
        paid_nxt   = paid_q;
        sess_p_nxt = sess_p;
        sess_t_nxt = sess_t;
        sess_c_nxt = sess_c;
        inv_p_nxt  = inv_p;
        inv_t_nxt  = inv_t;
        inv_c_nxt  = inv_c;
        less_nxt   = less_q;
        exact_nxt  = exact_q;
        more_nxt   = more_q;
        change_nxt = change_q;
        rv_nxt     = rv_q;
        reject_nxt = 1'b0;
        diff       = 5'd0;

        case (state)
            IDLE: begin
                reject_nxt = bus.coin_valid;
                if (bus.start) begin
                    cost_nxt   = bus.cost;
                    paid_nxt   = 4'd0;
                    sess_p_nxt = 2'd0;
                    sess_t_nxt = 2'd0;
                    sess_c_nxt = 2'd0;
                    state_nxt  = COLLECT;
                end
            end
            COLLECT: begin
`ifdef COIN_CANCEL_EN
                if (bus.cancel) begin
                    reject_nxt = bus.coin_valid;
                    paid_nxt   = 4'd0;
                    sess_p_nxt = 2'd0;
                    sess_t_nxt = 2'd0;
                    sess_c_nxt = 2'd0;
                    state_nxt  = IDLE;
                end else
`endif
                begin
                    reject_nxt = bus.coin_valid && !coin_ok;
                    if (coin_ok) begin
                        paid_nxt = coin_sum[3:0];
                        case (bus.coin_type)
                            2'b01:   sess_c_nxt = sess_c + 2'd1;
                            2'b10:   sess_t_nxt = sess_t + 2'd1;
                            default: sess_p_nxt = sess_p + 2'd1;
                        endcase
                    end
                    // Evaluation sees the coin accepted on this same edge.
                    if (bus.enter) begin
                        diff       = {1'b0, paid_nxt} - {1'b0, cost_q};
                        less_nxt   = paid_nxt <  cost_q;
                        exact_nxt  = paid_nxt == cost_q;
                        more_nxt   = paid_nxt >  cost_q;
                        change_nxt = (paid_nxt > cost_q) ? diff[3:0] : 4'd0;
                        rv_nxt     = 1'b1;
                        inv_p_nxt  = sat_add(inv_p, sess_p_nxt);
                        inv_t_nxt  = sat_add(inv_t, sess_t_nxt);
                        inv_c_nxt  = sat_add(inv_c, sess_c_nxt);
                        state_nxt  = RESULT;
                    end
                end
            end
            RESULT: begin
                reject_nxt = bus.coin_valid;
                if (bus.ack) begin
                    less_nxt   = 1'b0;
                    exact_nxt  = 1'b0;
                    more_nxt   = 1'b0;
                    change_nxt = 4'd0;
                    rv_nxt     = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cost_q   <= 4'd0;
            paid_q   <= 4'd0;
            sess_p   <= 2'd0;
            sess_t   <= 2'd0;
            sess_c   <= 2'd0;
            inv_p    <= 2'd0;
            inv_t    <= 2'd0;
            inv_c    <= 2'd0;
            less_q   <= 1'b0;
            exact_q  <= 1'b0;
            more_q   <= 1'b0;
            change_q <= 4'd0;
            rv_q     <= 1'b0;
            busy_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            cost_q   <= cost_nxt;
            paid_q   <= paid_nxt;
            sess_p   <= sess_p_nxt;
            sess_t   <= sess_t_nxt;
            sess_c   <= sess_c_nxt;
            inv_p    <= inv_p_nxt;
            inv_t    <= inv_t_nxt;
            inv_c    <= inv_c_nxt;
            less_q   <= less_nxt;
            exact_q  <= exact_nxt;
            more_q   <= more_nxt;
            change_q <= change_nxt;
            rv_q     <= rv_nxt;
            busy_q   <= busy_nxt;
            reject_q <= reject_nxt;
        end
    end

    assign bus.less         = less_q;
    assign bus.exact        = exact_q;
    assign bus.more         = more_q;
    assign bus.change       = change_q;
    assign bus.Pentagons    = inv_p;
    assign bus.Triangles    = inv_t;
    assign bus.Circles      = inv_c;
    assign bus.paid         = paid_q;
    assign bus.result_valid = rv_q;
    assign bus.busy         = busy_q;
    assign bus.coin_reject  = reject_q;

endmodule

// File: doc/coin_accumulator.md
COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset_L  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle pulse that opens a transaction and latches cost.
REQ-005 cost  input  4  item price in units, sampled only on an accepted start.
REQ-006 coin_valid  input  1  one-cycle pulse marking a coin insertion.
REQ-007 coin_type  input  2  coin code: 01 circle=1, 10 triangle=3, 11 pentagon=5; 00 is invalid.
REQ-008 enter  input  1  one-cycle pulse that ends payment and requests evaluation.
REQ-009 ack  input  1  downstream has consumed the result.
REQ-010 cancel  input  1  abort the transaction; present only with COIN_CANCEL_EN.
REQ-011 less, exact, more  output  1 each  paid<cost, paid==cost, paid>cost; one-hot while result_valid is high, else all 0.
REQ-012 change  output  4  paid-cost when more=1, else 0.
REQ-013 Pentagons, Triangles, Circles  output  2 each  committed coin inventory, saturating at 3.
REQ-014 paid  output  4  running total for the current transaction.
REQ-015 result_valid  output  1  high while the comparison outputs are valid.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 coin_reject  output  1  one-cycle pulse when a coin is refused.

Function
REQ-018 The FSM SHALL have states IDLE, COLLECT and RESULT, and all outputs SHALL be registered.
REQ-019 In IDLE, start SHALL latch cost, clear paid and the session coin counts, and move to COLLECT on the next edge; start SHALL be ignored in any other state.
REQ-020 In COLLECT, a valid coin SHALL add its value to paid and increment its 2-bit session count in the same edge.
REQ-021 A coin SHALL be rejected (coin_reject=1, no state change) if its code is 00, if paid+value>15, or if its session count is already 3.
REQ-022 Coins arriving in IDLE or RESULT SHALL be rejected.
REQ-023 In COLLECT, enter SHALL move to RESULT so that result_valid is high in cycle N+1 for enter in cycle N.
REQ-024 If coin_valid and enter occur in the same cycle, the coin SHALL be accepted or rejected first and any accepted coin SHALL be included in the evaluation.
REQ-025 On the transition to RESULT, each inventory count SHALL become min(3, inventory + session count).
REQ-026 On the transition to RESULT, less, exact, more and change SHALL be computed from paid and the latched cost using 5-bit internal arithmetic, so that change never wraps.
REQ-027 RESULT SHALL hold all outputs stable until ack, then return to IDLE on the next edge with result_valid, less, exact, more and change cleared.
REQ-028 In RESULT, paid SHALL hold its value until the next start.
REQ-029 ack outside RESULT SHALL be ignored.
REQ-030 When cost=0, enter with paid=0 SHALL yield exact=1.

Reset
REQ-031 Asserting reset_L low SHALL immediately force state to IDLE.
REQ-032 Reset SHALL clear paid, change, the latched cost, the session counts, all three inventory counts, less, exact, more, result_valid, busy and coin_reject to 0.
REQ-033 Reset mid-transaction SHALL discard the session and SHALL NOT commit coins to inventory.
REQ-034 Reset SHALL be released synchronously with respect to FSM activity, and the first start SHALL be honoured one cycle after release.

Configuration
REQ-035 With COIN_CANCEL_EN defined, the cancel port SHALL exist.
REQ-036 With COIN_CANCEL_EN defined, cancel in COLLECT SHALL return the block to IDLE, clear paid and the session counts, and leave inventory unchanged.
REQ-037 With COIN_CANCEL_EN defined, cancel SHALL have priority over enter and coin_valid in the same cycle, and SHALL be ignored in IDLE and RESULT.
REQ-038 With COIN_CANCEL_EN undefined, the cancel port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 The bench SHALL cover: start cost=7, coins 5, 3, enter -> next cycle result_valid=1, more=1, change=1, Pentagons=1, Triangles=1.
REQ-040 The bench SHALL cover: start cost=6, coins 3, 3, enter -> exact=1, change=0, Triangles=2.
REQ-041 The bench SHALL cover: start cost=9, coin 5 only, enter -> less=1, change=0; ack -> IDLE with outputs cleared.
REQ-042 The bench SHALL cover: paid=13, pentagon inserted -> coin_reject=1 and paid stays 13; fourth circle in one session -> rejected.
REQ-043 The bench SHALL cover: inventory Circles=3 plus a session of 2 circles committed -> Circles stays 3; coin_valid with enter in the same cycle -> that coin is counted in paid.
REQ-044 The bench SHALL cover, with COIN_CANCEL_EN: coins 5, 1, then cancel and enter in the same cycle -> IDLE, paid=0, inventory unchanged, result_valid=0; reset_L low mid-COLLECT -> all outputs 0.
